cache_set_assoc_store: RTL
==========================

Name: cache_set_assoc_store

Overview:
- N-way set-associative cache storage with built-in tag compare, per-set tree-PLRU replacement and a sequential invalidate-all (flush) engine.
- Successor to the passive cache memory wrapper. Lookups are pipelined, one request per cycle, with a fixed 1-cycle response; hit, way and victim are computed inside the block.
- Sits between the cache controller FSM and the sp_ram_wrap-based tag/valid/content arrays.

Parameters:
- WAY_COUNT, 2, associativity; power of two, 1..8.
- SET_COUNT, 64, sets; power of two, >=2.
- WAY_WORD_COUNT, 4, 32-bit words per line; power of two.
- ADDR_WIDTH, 32, byte address width.
- Derived address fields: word index = addr[2 +: WB] with WB=log2(WAY_WORD_COUNT); set index = next SB=log2(SET_COUNT) bits; tag = remaining TB = ADDR_WIDTH-2-WB-SB bits.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request strobe.
- req_ready_o  out  1  request accepted when req_valid_i & req_ready_o.
- req_op_i  in  2  request op: 00 lookup, 01 fill, 10 invalidate line, 11 treated as lookup.
- req_addr_i  in  ADDR_WIDTH  byte address; supplies set and tag.
- req_way_i  in  max(1,log2 WAY_COUNT)  target way for fill/invalidate.
- fill_line_i  in  32*WAY_WORD_COUNT  fill data.
- fill_be_i  in  4*WAY_WORD_COUNT  fill byte enables.
- flush_i  in  1  start invalidate-all.
- flush_busy_o  out  1  flush in progress.
- rsp_valid_o  out  1  response strobe, exactly 1 cycle after acceptance.
- rsp_hit_o  out  1  lookup hit.
- rsp_way_o  out  max(1,log2 WAY_COUNT)  hit way (lookup) or written way (fill/invalidate).
- rsp_victim_way_o  out  max(1,log2 WAY_COUNT)  PLRU victim for the set.
- rsp_line_o  out  32*WAY_WORD_COUNT  hit line data; 0 on miss.
- hit_count_o  out  32  optional statistics counter.
- miss_count_o  out  32  optional statistics counter.

Behaviour:
- FSM states: IDLE, FLUSH.
- req_ready_o = (state==IDLE) & !flush_i & !reset. flush_i wins over a simultaneous req_valid_i; that request is not accepted.
- Reset (synchronous): state<=FLUSH, flush counter<=0, rsp_valid_o<=0, rsp_hit_o<=0, rsp_way_o<=0, rsp_line_o<=0, stats<=0. flush_busy_o=1 while reset is high and throughout the flush. Valid RAM is not resettable and is cleared by the auto-flush.
- FLUSH:
  - Each cycle clears all valid bits and PLRU bits of set[counter]; counter increments.
  - After set SET_COUNT-1, next state is IDLE. Total SET_COUNT cycles after reset release or after the flush_i cycle.
  - flush_i asserted during FLUSH is ignored.
  - Reset mid-flush restarts at set 0.
- Lookup: all ways read in acceptance cycle N. At N+1: rsp_valid_o=1, tag compare against valid ways.
  - Multiple matching ways (corruption): lowest index wins.
  - Hit: rsp_hit_o=1, rsp_way_o=way, rsp_line_o=line. At end of N+1 the PLRU marks that way MRU.
  - Miss: rsp_hit_o=0, rsp_line_o=0, PLRU unchanged.
  - rsp_victim_way_o always reflects PLRU state before that cycle's update.
- Fill: at N writes tag, valid=1 and line (masked by fill_be_i) into req_way_i. Response at N+1 with rsp_hit_o=0, rsp_way_o=req_way_i. PLRU marks req_way_i MRU at end of N+1.
- Invalidate: at N clears valid of req_way_i in the addressed set; tag and data untouched. Response at N+1; PLRU unchanged.
- Back-to-back ops to the same set need no stall:
  - A write at N is visible to a read accepted at N+1.
  - A PLRU update at N+1 is visible to the response at N+2.
- Tree PLRU: WAY_COUNT-1 bits per set, all-zero PLRU state means victim is way 0. WAY_COUNT=1: victim always 0, no PLRU storage.

Optional Feature:
- Macro CACHE_SET_ASSOC_STATS_EN.
- Defined: hit_count_o / miss_count_o count lookup responses (hits / misses). Both saturate at 0xFFFFFFFF and clear on reset and on the cycle flush_i is accepted.
- Undefined: both ports tied to 0, no counter logic.

Test Plan:
- Reset held 1 cycle, then released -> flush_busy_o=1 and req_ready_o=0 for 64 cycles, then ready=1, busy=0.
- Lookup 0x0000_1040 (set 4, tag 4) after reset -> N+1: rsp_valid_o=1, hit=0, line=0, victim=0.
- Fill way0 at 0x1040 with line 0xDDDD_DDDD x4 and be=all ones; next cycle lookup 0x1044 -> hit=1, way=0, line=0xDDDD_DDDD x4; following lookup victim=1.
- Fill way1 at 0x2040 (set 4, tag 8), then lookup 0x1040 -> hit way0, and victim=1 on the next response. Lookup 0x2040 -> hit way1; next response victim=0.
- Invalidate way0 at 0x1040, then lookup 0x1040 -> hit=0. Lookup 0x2040 still hits way1.
- flush_i and req_valid_i asserted in the same cycle -> request not accepted, busy for 64 cycles, then lookups 0x1040 and 0x2040 miss. With CACHE_SET_ASSOC_STATS_EN defined: hit_count_o=0 and miss_count_o=2 after those lookups.

Source files
------------

// File: rtl/cache_set_assoc_store.sv
// N-way set-associative cache store: tag compare, per-set tree PLRU and a sequential flush engine.
// Optional hit/miss statistics counters are enabled by defining CACHE_SET_ASSOC_STATS_EN.
module cache_set_assoc_store #(
  parameter int WAY_COUNT      = 2,
  parameter int SET_COUNT      = 64,
  parameter int WAY_WORD_COUNT = 4,
  parameter int ADDR_WIDTH     = 32,
  localparam int WW = (WAY_COUNT > 1) ? $clog2(WAY_COUNT) : 1,
  localparam int LW = 32 * WAY_WORD_COUNT,
  localparam int BW = 4 * WAY_WORD_COUNT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0]            req_op_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [WW-1:0]         req_way_i,
  input  logic [LW-1:0]         fill_line_i,
  input  logic [BW-1:0]         fill_be_i,
  input  logic                  flush_i,
  output logic                  flush_busy_o,
  output logic                  rsp_valid_o,
  output logic                  rsp_hit_o,
  output logic [WW-1:0]         rsp_way_o,
  output logic [WW-1:0]         rsp_victim_way_o,
  output logic [LW-1:0]         rsp_line_o,
  output logic [31:0]           hit_count_o,
  output logic [31:0]           miss_count_o
);
  localparam int WB = $clog2(WAY_WORD_COUNT);
  localparam int SB = $clog2(SET_COUNT);
  localparam int TB = ADDR_WIDTH - 2 - WB - SB;
  localparam int LB = $clog2(WAY_COUNT);
  localparam int PW = (WAY_COUNT > 1) ? WAY_COUNT - 1 : 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [SB-1:0]   flush_cnt;

  logic [TB-1:0]        tag_mem   [SET_COUNT][WAY_COUNT];
  logic [LW-1:0]        data_mem  [SET_COUNT][WAY_COUNT];
  logic [WAY_COUNT-1:0] valid_mem [SET_COUNT];

  logic [SB-1:0]        req_set;
  logic [TB-1:0]        req_tag;
  logic                 accept, is_fill, is_inv, is_lookup;
  logic [WAY_COUNT-1:0] way_hit;
  logic                 hit_any;
  logic [WW-1:0]        hit_way;
  logic [LW-1:0]        be_mask;
  logic                 addr_unused;

  logic [SB-1:0]        rsp_set;
  logic                 rsp_touch;

  assign req_set     = req_addr_i[2+WB +: SB];
  assign req_tag     = req_addr_i[ADDR_WIDTH-1 -: TB];
  assign addr_unused = ^req_addr_i[1+WB:0];

  assign is_fill   = (req_op_i == 2'b01);
  assign is_inv    = (req_op_i == 2'b10);
  assign is_lookup = !is_fill && !is_inv;

  assign req_ready_o  = (state_q == IDLE) && !flush_i && !reset;
  assign flush_busy_o = reset || (state_q == FLUSH);
  assign accept       = req_valid_i && req_ready_o;

  // FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FLUSH;
      flush_cnt <= '0;
    end else begin
      state_q   <= state_d;
      flush_cnt <= (state_q == FLUSH) ? flush_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush_i) state_d = FLUSH;
      FLUSH:   if (flush_cnt == SB'(SET_COUNT - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tag compare in the acceptance cycle; the result is registered as the response
  for (genvar w = 0; w < WAY_COUNT; w++) begin : g_cmp
    assign way_hit[w] = valid_mem[req_set][w] && (tag_mem[req_set][w] == req_tag);
  end

  always_comb begin
    logic [WAY_COUNT-1:0] sh;
    hit_any = 1'b0;
    hit_way = '0;
    // Descending scan so the lowest matching way is the one left standing
    for (int w = WAY_COUNT - 1; w >= 0; w--) begin
      sh = way_hit >> w;
      if (sh[0]) begin
        hit_any = 1'b1;
        hit_way = WW'(w);
      end
    end
  end

  for (genvar b = 0; b < BW; b++) begin : g_be
    assign be_mask[8*b +: 8] = {8{fill_be_i[b]}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_o <= 1'b0;
      rsp_hit_o   <= 1'b0;
      rsp_way_o   <= '0;
      rsp_line_o  <= '0;
      rsp_set     <= '0;
      rsp_touch   <= 1'b0;
    end else begin
      rsp_valid_o <= accept;
      if (accept) begin
        rsp_hit_o  <= is_lookup && hit_any;
        rsp_way_o  <= is_lookup ? hit_way : req_way_i;
        rsp_line_o <= (is_lookup && hit_any) ? data_mem[req_set][hit_way] : '0;
        rsp_set    <= req_set;
        rsp_touch  <= is_fill || (is_lookup && hit_any);
      end
    end
  end

  // Storage arrays are not reset; the flush engine clears valid state instead
  always_ff @(posedge clk) begin
    if (accept && is_fill) begin
      tag_mem[req_set][req_way_i]  <= req_tag;
      data_mem[req_set][req_way_i] <= (data_mem[req_set][req_way_i] & ~be_mask)
                                    | (fill_line_i & be_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == FLUSH)
      valid_mem[flush_cnt] <= '0;
    else if (accept && is_fill)
      valid_mem[req_set][req_way_i] <= 1'b1;
    else if (accept && is_inv)
      valid_mem[req_set][req_way_i] <= 1'b0;
  end

  // Tree PLRU: node n stored at bit n-1, children 2n/2n+1; a 0 bit points left
  function automatic logic [WW-1:0] plru_victim(input logic [PW-1:0] t);
    int            node;
    logic [PW-1:0] sh;
    node = 1;
    for (int l = 0; l < LB; l++) begin
      sh   = t >> (node - 1);
      node = 2 * node + int'(sh[0]);
    end
    return WW'(node - WAY_COUNT);
  endfunction

  function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] t, input logic [WW-1:0] way);
    int            node;
    logic [PW-1:0] r;
    logic [WW-1:0] ws;
    node = 1;
    r    = t;
    for (int l = 0; l < LB; l++) begin
      ws   = way >> (LB - 1 - l);
      r    = (r & ~(PW'(1) << (node - 1))) | (PW'(!ws[0]) << (node - 1));
      node = 2 * node + int'(ws[0]);
    end
    return r;
  endfunction

  if (WAY_COUNT > 1) begin : g_plru
    logic [PW-1:0] plru_mem [SET_COUNT];
    always_ff @(posedge clk) begin
      if (rsp_valid_o && rsp_touch)
        plru_mem[rsp_set] <= plru_touch(plru_mem[rsp_set], rsp_way_o);
      // Flush clear lands last so it wins on a same-set collision
      if (state_q == FLUSH)
        plru_mem[flush_cnt] <= '0;
    end
    assign rsp_victim_way_o = plru_victim(plru_mem[rsp_set]);
  end else begin : g_no_plru
    assign rsp_victim_way_o = '0;
  end

`ifdef CACHE_SET_ASSOC_STATS_EN
  logic [31:0] hit_q, miss_q;
  always_ff @(posedge clk) begin
    if (reset || (flush_i && state_q == IDLE)) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (accept && is_lookup) begin
      if (hit_any && hit_q != '1)   hit_q  <= hit_q + 1'b1;
      if (!hit_any && miss_q != '1) miss_q <= miss_q + 1'b1;
    end
  end
  assign hit_count_o  = hit_q;
  assign miss_count_o = miss_q;
`else
  assign hit_count_o  = '0;
  assign miss_count_o = '0;
`endif

endmodule
